// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module  : riscv_mem_pkg
// Brief   : Shared memory-system widths, arbiter state/grant types and the
//           round-robin pick used by memory_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // On a tie the requester that was not served last wins.
    function automatic grant_t rr_pick(input logic req_i, input logic req_d, input grant_t last);
        if (req_i && req_d) return (last == GNT_I) ? GNT_D : GNT_I;
        return req_d ? GNT_D : GNT_I;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module  : memory_arbiter
// Brief   : Round-robin arbiter sharing one main-memory block port between the
//           instruction cache (read) and data cache (read/write-back).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
    parameter int ADDR_W   = riscv_mem_pkg::ADDR_W,
    parameter int BLOCK_W  = riscv_mem_pkg::BLOCK_W,
    parameter int MAX_WAIT = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_Read,
    output logic               mem_Write,
    output logic [ADDR_W-1:0]  mem_Address,
    output logic [BLOCK_W-1:0] mem_Writedata,
    input  logic [BLOCK_W-1:0] mem_Readdata,
    input  logic               mem_BusyWait,
    output logic               err_timeout
);

    import riscv_mem_pkg::*;

    localparam int                 c_cnt_w     = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MAX_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = {c_cnt_w{1'b1}};

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    grant_t              r_last_grant;
    grant_t              w_grant_pick;
    logic                r_seen_busy;
    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [BLOCK_W-1:0]  r_wdata;
    logic                r_we;
    logic [BLOCK_W-1:0]  r_i_rdata;
    logic [BLOCK_W-1:0]  r_d_rdata;
    logic                r_err;

    logic w_i_req;
    logic w_d_req;
    logic w_any_req;
    logic w_serving;
    logic w_complete;
    logic w_expire;

    assign w_i_req      = i_read;
    assign w_d_req      = d_read | d_write;
    assign w_any_req    = w_i_req | w_d_req;
    assign w_grant_pick = rr_pick(w_i_req, w_d_req, r_last_grant);
    assign w_serving    = (r_state == SERVE_I) || (r_state == SERVE_D);
    // Completion needs a busy phase first; an early low busywait is ignored.
    assign w_complete   = w_serving && r_seen_busy && !mem_BusyWait;
    assign w_expire     = w_serving && !w_complete && (r_wait_cnt >= c_wait_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = (w_grant_pick == GNT_D) ? SERVE_D : SERVE_I;
            SERVE_I,
            SERVE_D: if (w_complete || w_expire) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_I;
            r_seen_busy  <= 1'b0;
            r_wait_cnt   <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == IDLE && w_any_req) begin
                r_last_grant <= w_grant_pick;
                if (w_grant_pick == GNT_D) begin
                    r_addr  <= d_address;
                    r_wdata <= d_writedata;
                    r_we    <= d_write;
                end else begin
                    r_addr  <= i_address;
                    r_we    <= 1'b0;
                end
            end

            if (w_serving) begin
                if (w_complete || w_expire) begin
                    r_seen_busy <= 1'b0;
                    r_wait_cnt  <= '0;
                end else begin
                    if (mem_BusyWait) r_seen_busy <= 1'b1;
                    if (r_wait_cnt != c_cnt_max) r_wait_cnt <= r_wait_cnt + 1'b1;
                end

                if (w_complete && !r_we) begin
                    if (r_state == SERVE_I) r_i_rdata <= mem_Readdata;
                    else                    r_d_rdata <= mem_Readdata;
                end

                if (w_expire) r_err <= 1'b1;
            end
        end
    end

    assign mem_Read      = (r_state == SERVE_I) || ((r_state == SERVE_D) && !r_we);
    assign mem_Write     = (r_state == SERVE_D) && r_we;
    assign mem_Address   = r_addr;
    assign mem_Writedata = r_wdata;

    assign i_readdata  = r_i_rdata;
    assign d_readdata  = r_d_rdata;
    assign err_timeout = r_err;

    assign i_busywait = w_i_req && !((r_state == DONE) && (r_last_grant == GNT_I));
    assign d_busywait = w_d_req && !((r_state == DONE) && (r_last_grant == GNT_D));

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module  : tb_memory_arbiter
// Brief   : Directed self-checking bench for memory_arbiter with a small
//           latency-5 block memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         i_read;
    logic [27:0]  i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_Read;
    logic         mem_Write;
    logic [27:0]  mem_Address;
    logic [127:0] mem_Writedata;
    logic [127:0] mem_Readdata;
    logic         mem_BusyWait;
    logic         err_timeout;

    int passed = 0;
    int total  = 0;

    memory_arbiter #(.ADDR_W(28), .BLOCK_W(128), .MAX_WAIT(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Address(mem_Address),
        .mem_Writedata(mem_Writedata), .mem_Readdata(mem_Readdata), .mem_BusyWait(mem_BusyWait),
        .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for the first 5 strobe cycles, or forever when hung.
    logic hang = 1'b0;
    int   mcnt = 0;
    logic strobe;
    assign strobe = mem_Read | mem_Write;
    always @(posedge CLK) mcnt <= strobe ? ((mcnt < 1000) ? mcnt + 1 : mcnt) : 0;
    assign mem_BusyWait = strobe && (hang || (mcnt < 5));

    function automatic logic [127:0] exp_block(input logic [27:0] a);
        return {32'hDEADBEEF, 4'h0, a, 64'h0123_4567_89AB_CDEF};
    endfunction
    assign mem_Readdata = exp_block(mem_Address);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; i_read = 0; d_read = 0; d_write = 0;
        i_address = '0; d_address = '0; d_writedata = '0;
        tick(); tick();
        total++; if (mem_Read !== 1'b0) $display("FAIL reset_mem_read got %b exp 0", mem_Read); else passed++;
        total++; if (mem_Write !== 1'b0) $display("FAIL reset_mem_write got %b exp 0", mem_Write); else passed++;
        total++; if (mem_Address !== 28'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_Address); else passed++;
        total++; if (mem_Writedata !== 128'h0) $display("FAIL reset_mem_wdata got %h exp 0", mem_Writedata); else passed++;
        total++; if (i_readdata !== 128'h0) $display("FAIL reset_i_rdata got %h exp 0", i_readdata); else passed++;
        total++; if (d_readdata !== 128'h0) $display("FAIL reset_d_rdata got %h exp 0", d_readdata); else passed++;
        total++; if (err_timeout !== 1'b0) $display("FAIL reset_err got %b exp 0", err_timeout); else passed++;
        RESET = 1'b0;
        tick();
        total++; if ({i_busywait, d_busywait, mem_Read} !== 3'b000)
            $display("FAIL idle_no_req got %b exp 000", {i_busywait, d_busywait, mem_Read}); else passed++;
    endtask

    task automatic test_single_read();
        int first, nstrb, done;
        logic done_strobe, addr_ok;
        logic [127:0] got;
        first = -1; nstrb = 0; done = -1; done_strobe = 1'b1; addr_ok = 1'b1; got = '0;
        i_address = 28'h0000010; i_read = 1'b1;
        for (int c = 1; c <= 40 && done < 0; c++) begin
            tick();
            if (!i_busywait) begin
                done = c; got = i_readdata; done_strobe = mem_Read; i_read = 1'b0;
            end else if (mem_Read) begin
                nstrb++;
                if (first < 0) first = c;
                if (mem_Address !== 28'h0000010) addr_ok = 1'b0;
            end
        end
        total++; if (first != 1) $display("FAIL t1_first_strobe got %0d exp 1", first); else passed++;
        total++; if (nstrb != 6) $display("FAIL t1_strobe_cycles got %0d exp 6", nstrb); else passed++;
        total++; if (done != 7) $display("FAIL t1_done_cycle got %0d exp 7", done); else passed++;
        total++; if (done_strobe !== 1'b0) $display("FAIL t1_read_in_done got %b exp 0", done_strobe); else passed++;
        total++; if (!addr_ok) $display("FAIL t1_mem_addr got bad exp 0000010"); else passed++;
        total++; if (got !== exp_block(28'h0000010)) $display("FAIL t1_rdata got %h exp %h", got, exp_block(28'h0000010)); else passed++;
        tick(); tick();
        total++; if (i_readdata !== exp_block(28'h0000010)) $display("FAIL t1_rdata_hold got %h exp %h", i_readdata, exp_block(28'h0000010)); else passed++;
    endtask

    task automatic test_tie();
        int d_start, i_start, d_done, i_done;
        logic [127:0] got_d, got_i;
        d_start = -1; i_start = -1; d_done = -1; i_done = -1; got_d = '0; got_i = '0;
        tick();
        i_address = 28'h0000020; d_address = 28'h0000030;
        i_read = 1'b1; d_read = 1'b1;
        for (int c = 1; c <= 60 && i_done < 0; c++) begin
            tick();
            if (mem_Read && mem_Address === 28'h0000030 && d_start < 0) d_start = c;
            if (mem_Read && mem_Address === 28'h0000020 && i_start < 0) i_start = c;
            if (d_read && !d_busywait) begin d_done = c; got_d = d_readdata; d_read = 1'b0; end
            if (i_read && !i_busywait) begin i_done = c; got_i = i_readdata; i_read = 1'b0; end
        end
        total++; if (d_start != 1) $display("FAIL t2_d_first got %0d exp 1", d_start); else passed++;
        total++; if (d_done != 7) $display("FAIL t2_d_done got %0d exp 7", d_done); else passed++;
        total++; if (i_start != 9) $display("FAIL t2_i_start got %0d exp 9", i_start); else passed++;
        total++; if (i_done != 15) $display("FAIL t2_i_done got %0d exp 15", i_done); else passed++;
        total++; if (got_d !== exp_block(28'h0000030)) $display("FAIL t2_d_rdata got %h exp %h", got_d, exp_block(28'h0000030)); else passed++;
        total++; if (got_i !== exp_block(28'h0000020)) $display("FAIL t2_i_rdata got %h exp %h", got_i, exp_block(28'h0000020)); else passed++;
    endtask

    task automatic test_write();
        int done, nw, bad;
        logic rd_seen, done_wr;
        done = -1; nw = 0; bad = 0; rd_seen = 1'b0; done_wr = 1'b1;
        tick(); tick();
        d_address = 28'h00000A0; d_writedata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        d_write = 1'b1;
        for (int c = 1; c <= 40 && done < 0; c++) begin
            tick();
            if (!d_busywait) begin
                done = c; done_wr = mem_Write; d_write = 1'b0;
            end else begin
                if (mem_Read) rd_seen = 1'b1;
                if (mem_Write) begin
                    nw++;
                    if (mem_Address !== 28'h00000A0 ||
                        mem_Writedata !== 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF) bad++;
                end
            end
            if (c == 3) begin d_address = 28'hFFFFFFF; d_writedata = '0; end
        end
        total++; if (done != 7) $display("FAIL t3_done got %0d exp 7", done); else passed++;
        total++; if (nw != 6) $display("FAIL t3_write_cycles got %0d exp 6", nw); else passed++;
        total++; if (bad != 0) $display("FAIL t3_latched_addr_data got %0d bad cycles exp 0", bad); else passed++;
        total++; if (rd_seen !== 1'b0) $display("FAIL t3_no_read got %b exp 0", rd_seen); else passed++;
        total++; if (done_wr !== 1'b0) $display("FAIL t3_write_in_done got %b exp 0", done_wr); else passed++;
        total++; if (d_readdata !== exp_block(28'h0000030)) $display("FAIL t3_d_rdata_kept got %h exp %h", d_readdata, exp_block(28'h0000030)); else passed++;
    endtask

    task automatic test_round_robin();
        int d_n, i_n, ng, bad;
        logic prev;
        logic [3:0] seq;
        d_n = 0; i_n = 0; ng = 0; bad = 0; prev = 1'b0; seq = '0;
        RESET = 1'b1; tick(); RESET = 1'b0;
        d_address = 28'h0000034; i_address = 28'h0000024;
        d_read = 1'b1; i_read = 1'b1;
        for (int c = 1; c <= 100 && (d_n < 2 || i_n < 2); c++) begin
            tick();
            if (mem_Read && !prev) begin
                seq = {seq[2:0], (mem_Address === 28'h0000034)};
                ng++;
            end
            prev = mem_Read;
            if (d_read && !d_busywait) begin
                d_n++; d_read = 1'b0;
                if (d_readdata !== exp_block(28'h0000034)) bad++;
            end else if (!d_read && d_n < 2) d_read = 1'b1;
            if (i_read && !i_busywait) begin
                i_n++; i_read = 1'b0;
                if (i_readdata !== exp_block(28'h0000024)) bad++;
            end else if (!i_read && i_n < 2) i_read = 1'b1;
        end
        d_read = 1'b0; i_read = 1'b0;
        total++; if (ng != 4) $display("FAIL t4_grant_count got %0d exp 4", ng); else passed++;
        total++; if (seq !== 4'b1010) $display("FAIL t4_grant_order got %b exp 1010 (1=D)", seq); else passed++;
        total++; if (bad != 0) $display("FAIL t4_rdata got %0d bad exp 0", bad); else passed++;
        total++; if (d_n != 2 || i_n != 2) $display("FAIL t4_served got d=%0d i=%0d exp 2/2", d_n, i_n); else passed++;
    endtask

    task automatic test_reset_mid_serve();
        int first, done;
        logic [127:0] got;
        first = -1; done = -1; got = '0;
        tick(); tick();
        i_address = 28'h0000050; i_read = 1'b1;
        tick(); tick(); tick();
        total++; if (mem_Read !== 1'b1) $display("FAIL t5_serving got %b exp 1", mem_Read); else passed++;
        RESET = 1'b1;
        tick();
        total++; if (mem_Read !== 1'b0) $display("FAIL t5_strobe_drop got %b exp 0", mem_Read); else passed++;
        total++; if (i_readdata !== 128'h0) $display("FAIL t5_i_rdata_clr got %h exp 0", i_readdata); else passed++;
        total++; if (d_readdata !== 128'h0) $display("FAIL t5_d_rdata_clr got %h exp 0", d_readdata); else passed++;
        total++; if (i_busywait !== 1'b1) $display("FAIL t5_busy_held got %b exp 1", i_busywait); else passed++;
        RESET = 1'b0;
        for (int c = 5; c <= 40 && done < 0; c++) begin
            tick();
            if (!i_busywait) begin done = c; got = i_readdata; i_read = 1'b0; end
            else if (mem_Read && first < 0) first = c;
        end
        total++; if (first != 5) $display("FAIL t5_restart got %0d exp 5", first); else passed++;
        total++; if (done != 11) $display("FAIL t5_done got %0d exp 11", done); else passed++;
        total++; if (got !== exp_block(28'h0000050)) $display("FAIL t5_rdata got %h exp %h", got, exp_block(28'h0000050)); else passed++;
    endtask

    task automatic test_timeout();
        int nstrb, done, err_first;
        logic [127:0] got;
        nstrb = 0; done = -1; err_first = -1; got = '0;
        tick(); tick();
        hang = 1'b1;
        i_address = 28'h0000070; i_read = 1'b1;
        for (int c = 1; c <= 60 && done < 0; c++) begin
            tick();
            if (err_timeout && err_first < 0) err_first = c;
            if (!i_busywait) begin done = c; got = i_readdata; i_read = 1'b0; end
            else if (mem_Read) nstrb++;
        end
        hang = 1'b0;
        total++; if (nstrb != 16) $display("FAIL t6_serve_cycles got %0d exp 16", nstrb); else passed++;
        total++; if (done != 17) $display("FAIL t6_release got %0d exp 17", done); else passed++;
        total++; if (err_first != 17) $display("FAIL t6_err_rise got %0d exp 17", err_first); else passed++;
        total++; if (got !== exp_block(28'h0000050)) $display("FAIL t6_stale_data got %h exp %h", got, exp_block(28'h0000050)); else passed++;
        tick(); tick();
        done = -1; got = '0;
        i_address = 28'h0000080; i_read = 1'b1;
        for (int c = 1; c <= 40 && done < 0; c++) begin
            tick();
            if (!i_busywait) begin done = c; got = i_readdata; i_read = 1'b0; end
        end
        total++; if (done != 7) $display("FAIL t6_next_done got %0d exp 7", done); else passed++;
        total++; if (got !== exp_block(28'h0000080)) $display("FAIL t6_next_rdata got %h exp %h", got, exp_block(28'h0000080)); else passed++;
        total++; if (err_timeout !== 1'b1) $display("FAIL t6_err_sticky got %b exp 1", err_timeout); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write();
        test_round_robin();
        test_reset_mid_serve();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
